// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and pixel packing shared by the capture and display paths.
package vga_timing_pkg;

  localparam int VGA_LINE_PERIOD  = 800;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BACK       = 48;
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_FRAME_PERIOD = 525;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BACK       = 33;
  localparam int VGA_V_ACTIVE     = 480;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_SYNC,
    CAP_LOCKED
  } cap_state_t;

  function automatic logic [7:0] rgb332(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers hs/vs once and flags their falling edges, aligned with the registered pixel.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic hs,
  input  logic vs,
  output logic hs_fall,
  output logic vs_fall
);

  logic hs_q, vs_q, hs_d, vs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;

endmodule

// File: rtl/vga_rx_capture.sv
// Recovers VGA position from sync edges, locks after one clean frame and writes a window
// of RGB332 pixels to the image RAM; two register stages from vga_* to the write port.
module vga_rx_capture
  import vga_timing_pkg::*;
#(
  parameter int LINE_PERIOD  = VGA_LINE_PERIOD,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BACK       = VGA_H_BACK,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int FRAME_PERIOD = VGA_FRAME_PERIOD,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BACK       = VGA_V_BACK,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int WIN_X        = 220,
  parameter int WIN_Y        = 140,
  parameter int WIN_W        = 200,
  parameter int WIN_H        = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic        ram_wr_en,
  output logic [15:0] ram_wr_addr,
  output logic [7:0]  ram_wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        timing_err
);

  localparam int H_ACT0 = H_SYNC + H_BACK;
  localparam int V_ACT0 = V_SYNC + V_BACK;
  // Window bounds in raw counter space, clipped to the active area.
  localparam int H_HI_I = (WIN_X + WIN_W < H_ACTIVE) ? H_ACT0 + WIN_X + WIN_W : H_ACT0 + H_ACTIVE;
  localparam int V_HI_I = (WIN_Y + WIN_H < V_ACTIVE) ? V_ACT0 + WIN_Y + WIN_H : V_ACT0 + V_ACTIVE;

  localparam logic [11:0] H_LO       = 12'(H_ACT0 + WIN_X);
  localparam logic [11:0] H_HI       = 12'(H_HI_I);
  localparam logic [10:0] V_LO       = 11'(V_ACT0 + WIN_Y);
  localparam logic [10:0] V_HI       = 11'(V_HI_I);
  localparam logic [10:0] LINE_LAST  = 11'(LINE_PERIOD - 1);
  localparam logic [9:0]  FRAME_LAST = 10'(FRAME_PERIOD - 1);
  localparam logic [15:0] LAST_ADDR  = 16'(WIN_W * WIN_H - 1);

  logic       hs_fall, vs_fall;
  logic [7:0] r_q, g_q, b_q;

  vga_sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .hs      (vga_hs),
    .vs      (vga_vs),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
    end else begin
      r_q <= vga_r;
      g_q <= vga_g;
      b_q <= vga_b;
    end
  end

  logic [10:0] h_cnt, h_cnt_q;
  logic [9:0]  v_cnt, v_cnt_q;
  logic        line_err, frame_err, in_win, wr;
  logic [15:0] addr_cnt;
  logic        addr_full;
  logic        clean;
  cap_state_t  state;

  // h_cnt/v_cnt describe the pixel currently held in r_q/g_q/b_q.
  always_comb begin
    h_cnt = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
    if (hs_fall) h_cnt = 11'd0;
    v_cnt = v_cnt_q;
    if (vs_fall) v_cnt = 10'd0;
    else if (hs_fall) v_cnt = v_cnt_q + 10'd1;
  end

  assign line_err  = hs_fall && (h_cnt_q != LINE_LAST);
  assign frame_err = vs_fall && (v_cnt_q != FRAME_LAST);
  assign in_win    = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI) &&
                     ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
  assign wr        = (state == CAP_LOCKED) && in_win && !addr_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt;
      v_cnt_q <= v_cnt;
    end
  end

  // Holds at the last address once written so a stray extra pixel cannot wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= 16'd0;
      addr_full <= 1'b0;
    end else if (vs_fall) begin
      addr_cnt  <= 16'd0;
      addr_full <= 1'b0;
    end else if (wr) begin
      if (addr_cnt == LAST_ADDR) addr_full <= 1'b1;
      else addr_cnt <= addr_cnt + 16'd1;
    end
  end

  // clean tracks "no line error since SYNC was (re)entered".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CAP_IDLE;
      clean      <= 1'b0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      case (state)
        CAP_IDLE: begin
          if (vs_fall) begin
            state <= CAP_SYNC;
            clean <= 1'b1;
          end
        end
        CAP_SYNC: begin
          if (vs_fall) begin
            if (clean && !line_err && !frame_err) begin
              state  <= CAP_LOCKED;
              locked <= 1'b1;
            end
            clean <= 1'b1;
          end else if (line_err) begin
            clean <= 1'b0;
          end
        end
        CAP_LOCKED: begin
          if (line_err || frame_err) begin
            state      <= CAP_SYNC;
            locked     <= 1'b0;
            timing_err <= 1'b1;
            clean      <= 1'b1;
          end
        end
        default: begin
          state  <= CAP_IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= 16'd0;
      ram_wr_data <= 8'd0;
      frame_done  <= 1'b0;
    end else begin
      ram_wr_en   <= wr;
      ram_wr_addr <= addr_cnt;
      ram_wr_data <= rgb332(r_q, g_q, b_q);
      frame_done  <= wr && (addr_cnt == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Scoreboard bench for vga_rx_capture on a scaled-down 40x30 timing with a 6x5 window.
module tb_vga_rx_capture;

  localparam int LP = 40, HS = 4, HB = 4, HA = 24;
  localparam int FP = 30, VS = 2, VB = 3, VA = 20;
  localparam int WX = 5, WY = 4, WW = 6, WH = 5;
  // Window origin in raw counter space: 4+4+5 = 13, 2+3+4 = 9; last address 6*5-1.
  localparam int WX0 = 13, WY0 = 9, WLAST = 29;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1;
  logic        ram_wr_en, frame_done, locked, timing_err;
  logic [15:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;

  vga_rx_capture #(
    .LINE_PERIOD(LP), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .FRAME_PERIOD(FP), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .frame_done(frame_done), .locked(locked), .timing_err(timing_err)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  err_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives lines [first..last] of a frame; one line may be one clock short.
  task automatic send_lines(input int first, input int last, input int short_line,
                            input bit capture);
    wr_t e;
    int  len;
    for (int l = first; l <= last; l++) begin
      len = (l == short_line) ? LP - 1 : LP;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        vga_hs = (c < HS) ? 1'b0 : 1'b1;
        vga_vs = (l < VS) ? 1'b0 : 1'b1;
        if (c == WX0 && l == WY0) begin
          vga_r = 8'hFF; vga_g = 8'h00; vga_b = 8'hC0;
        end else begin
          vga_r = 8'(c * 37 + l);
          vga_g = 8'(l * 29 + c * 3);
          vga_b = 8'((c * 11) ^ (l * 5));
        end
        if (capture && l >= WY0 && l < WY0 + WH && c >= WX0 && c < WX0 + WW) begin
          e.addr = 16'((l - WY0) * WW + (c - WX0));
          e.data = (c == WX0 && l == WY0) ? 8'hE3 : {vga_r[7:5], vga_g[7:5], vga_b[7:6]};
          e.done = (e.addr == 16'(WLAST));
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (ram_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(ram_wr_addr), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_wr_addr), 32'(e.addr));
        check("wr_data", 32'(ram_wr_data), 32'(e.data));
        check("frame_done", 32'(frame_done), 32'(e.done));
      end
    end else if (frame_done) begin
      check("frame_done_without_write", 32'(frame_done), 32'd0);
    end
    if (timing_err) begin
      err_cycles++;
      check("locked_low_with_err", 32'(locked), 32'd0);
    end
  end

  initial begin
    // Reset held during a live pixel stream.
    rst_n = 1'b0;
    send_lines(0, 14, -1, 1'b0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("rst_wr_data", 32'(ram_wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_timing_err", 32'(timing_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_lines(15, FP - 1, -1, 1'b0);
    check("locked_before_vs", 32'(locked), 32'd0);

    // First vs: IDLE -> SYNC; second vs locks and that frame is captured.
    send_lines(0, FP - 1, -1, 1'b0);
    check("locked_after_1st_vs", 32'(locked), 32'd0);
    send_lines(0, FP - 1, -1, 1'b1);
    check("locked_after_2nd_vs", 32'(locked), 32'd1);
    check("queue_empty_b", 32'(exp_q.size()), 32'd0);
    send_lines(0, FP - 1, -1, 1'b1);
    check("locked_frame_c", 32'(locked), 32'd1);
    check("queue_empty_c", 32'(exp_q.size()), 32'd0);
    check("no_err_clean", 32'(err_cycles), 32'd0);

    // Short line while locked: one error pulse, no writes, relock at next vs.
    send_lines(0, FP - 1, 2, 1'b0);
    check("err_short_line", 32'(err_cycles), 32'd1);
    check("unlocked_short_line", 32'(locked), 32'd0);
    send_lines(0, FP - 1, -1, 1'b1);
    check("relocked", 32'(locked), 32'd1);
    check("queue_empty_e", 32'(exp_q.size()), 32'd0);

    // Short last line: error coincides with vs; then a 29-line frame in SYNC.
    send_lines(0, FP - 1, FP - 1, 1'b1);
    check("queue_empty_f", 32'(exp_q.size()), 32'd0);
    send_lines(0, FP - 2, -1, 1'b0);
    check("err_at_vs", 32'(err_cycles), 32'd2);
    check("unlocked_at_vs", 32'(locked), 32'd0);
    send_lines(0, FP - 1, -1, 1'b0);
    check("short_frame_no_lock", 32'(locked), 32'd0);
    check("short_frame_no_err", 32'(err_cycles), 32'd2);
    send_lines(0, FP - 1, -1, 1'b1);
    check("lock_after_good_frame", 32'(locked), 32'd1);
    check("queue_empty_i", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame while capturing: outputs clear at once, no further writes.
    send_lines(0, WY0 + 1, -1, 1'b1);
    check("queue_empty_partial", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(ram_wr_en), 32'd0);
    check("abort_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("abort_locked", 32'(locked), 32'd0);
    send_lines(WY0 + 2, FP - 1, -1, 1'b0);
    check("abort_no_err", 32'(err_cycles), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
